// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared types for the sequential ALU.
//   op_e    - operation codes (14 and 15 are unassigned / illegal)
//   state_e - control FSM states
//   is_iter - true for the multi-cycle multiply/divide ops
package seq_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_SLT   = 4'd4,
        OP_SLTU  = 4'd5,
        OP_XOR   = 4'd6,
        OP_SLL   = 4'd7,
        OP_SRL   = 4'd8,
        OP_SRA   = 4'd9,
        OP_MUL   = 4'd10,
        OP_MULHU = 4'd11,
        OP_DIVU  = 4'd12,
        OP_REMU  = 4'd13
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_iter(input logic [3:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// seq_alu_iter: WIDTH-step unsigned multiply / divide engine.
//   clk, rst_n - clock, async active-low reset (aborts any iteration)
//   start      - load operands and begin; ignored state is overwritten
//   op_sel     - 0 MUL, 1 MULHU, 2 DIVU, 3 REMU
//   a, b       - operands, sampled on start
//   done       - one-cycle pulse the cycle after the last step
//   res        - selected result, stable while idle
module seq_alu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res
);
    localparam int CNT_W = $clog2(WIDTH);

    // hi/lo form one 2*WIDTH register: product {hi,lo} for multiply,
    // {remainder, quotient-in-progress} for divide. m holds multiplicand/divisor.
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        rem_sh   = {hi_q, lo_q[WIDTH-1]};
        div_ge   = rem_sh >= {1'b0, m_q};
        // Only used when div_ge, where the true difference fits in WIDTH bits.
        div_diff = rem_sh[WIDTH-1:0] - m_q;

        hi_d   = hi_q;
        lo_d   = lo_q;
        m_d    = m_q;
        op_d   = op_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;

        if (start) begin
            hi_d   = '0;
            lo_d   = op_sel[1] ? a : b;
            m_d    = op_sel[1] ? b : a;
            op_d   = op_sel;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (op_q[1]) begin
                // Divide by zero falls out naturally: every step subtracts 0,
                // giving an all-ones quotient and the dividend as remainder.
                hi_d = div_ge ? div_diff : rem_sh[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], div_ge};
            end else begin
                hi_d = mul_sum[WIDTH:1];
                lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            m_q    <= '0;
            op_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            m_q    <= m_d;
            op_q   <= op_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // MULHU and REMU take the high half, MUL and DIVU the low half.
    assign res  = op_q[0] ? hi_q : lo_q;
    assign done = done_q;

endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with single-cycle logic/arith/shift ops and
// iterative unsigned MUL/MULHU/DIVU/REMU.
//   clk, rst_n          - clock, async active-low reset
//   in_valid/in_ready   - request handshake; op, src_a, src_b latched on transfer
//   out_valid/out_ready - result handshake; result and flags held until retired
//   result              - registered result
//   zero, negative      - derived from result
//   carry, overflow     - ADD/SUB only
//   illegal             - unassigned op code (result 0)
//
// state | meaning
// IDLE  | no result pending, ready for a request
// BUSY  | iterative op running in seq_alu_iter
// DONE  | result valid, waiting for out_ready
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [4:0]       flags_q, flags_d;   // {zero, negative, carry, overflow, illegal}

    logic             accept, op_iter, iter_start, iter_done, load_alu, load_iter;
    logic [WIDTH-1:0] iter_res;

    logic [WIDTH:0]   sum, diff;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_ill;

    assign in_ready   = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid  = (state_q == DONE);
    assign accept     = in_valid && in_ready;
    assign op_iter    = is_iter(op);
    assign iter_start = accept && op_iter;
    assign load_alu   = accept && !op_iter;
    assign load_iter  = (state_q == BUSY) && iter_done;

    // Codes 10..13 map to engine selects 0..3 via bits {2,0}.
    seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (iter_start),
        .op_sel ({op[2], op[0]}),
        .a      (src_a),
        .b      (src_b),
        .done   (iter_done),
        .res    (iter_res)
    );

    always_comb begin
        sum     = {1'b0, src_a} + {1'b0, src_b};
        diff    = {1'b0, src_a} - {1'b0, src_b};
        shamt   = src_b[SHAMT_W-1:0];
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = ~diff[WIDTH];   // not-borrow
                alu_v   = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_SLL:  alu_res = src_a << shamt;
            OP_SRL:  alu_res = src_a >> shamt;
            OP_SRA:  alu_res = $signed(src_a) >>> shamt;
            default: alu_ill = !op_iter;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = op_iter ? BUSY : DONE;
            BUSY: if (iter_done) state_d = DONE;
            DONE: begin
                if (out_ready) begin
                    if (accept) state_d = op_iter ? BUSY : DONE;
                    else        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        result_d = result_q;
        flags_d  = flags_q;
        if (load_alu) begin
            result_d = alu_res;
            flags_d  = {(alu_res == '0), alu_res[WIDTH-1], alu_c, alu_v, alu_ill};
        end else if (load_iter) begin
            result_d = iter_res;
            flags_d  = {(iter_res == '0), iter_res[WIDTH-1], 3'b000};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign result   = result_q;
    assign zero     = flags_q[4];
    assign negative = flags_q[3];
    assign carry    = flags_q[2];
    assign overflow = flags_q[1];
    assign illegal  = flags_q[0];

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         in_ready, out_valid, zero, negative, carry, overflow, illegal;
    logic [W-1:0] result;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .negative(negative),
        .carry(carry), .overflow(overflow), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] res;
        logic z, n, c, v, ill;
    } out_t;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    bit   rnd = 1'b0;
    out_t m_out, m_pend;
    bit   m_valid;
    int   m_busy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: results straight from the arithmetic definition of each op.
    function automatic out_t ref_alu(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        out_t r;
        longint sa, sb, s;
        longint unsigned ua, ub, p;
        int sh;
        r  = '0;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        sh = int'(b[4:0]);
        case (o)
            4'd0: begin
                p = ua + ub; r.res = p[W-1:0]; r.c = p > 64'hFFFF_FFFF;
                s = sa + sb; r.v = (s > SMAX) || (s < SMIN);
            end
            4'd1: begin
                p = ua - ub; r.res = p[W-1:0]; r.c = ua >= ub;
                s = sa - sb; r.v = (s > SMAX) || (s < SMIN);
            end
            4'd2: r.res = a & b;
            4'd3: r.res = a | b;
            4'd4: r.res = (sa < sb) ? 1 : 0;
            4'd5: r.res = (ua < ub) ? 1 : 0;
            4'd6: r.res = a ^ b;
            4'd7: r.res = a << sh;
            4'd8: r.res = a >> sh;
            4'd9: begin s = sa >>> sh; r.res = s[W-1:0]; end
            4'd10: begin p = ua * ub; r.res = p[W-1:0]; end
            4'd11: begin p = ua * ub; r.res = p[63:32]; end
            4'd12: begin if (ub == 0) r.res = '1; else begin p = ua / ub; r.res = p[W-1:0]; end end
            4'd13: begin if (ub == 0) r.res = a; else begin p = ua % ub; r.res = p[W-1:0]; end end
            default: r.ill = 1'b1;
        endcase
        r.z = (r.res == '0);
        r.n = r.res[W-1];
        return r;
    endfunction

    // Cycle model: an accepted op produces its result 1 cycle later, or
    // WIDTH+1 cycles later for multiply/divide; nothing is accepted while a
    // long op is outstanding or an unretired result blocks the output.
    initial begin
        bit   rdy, acc;
        out_t e;
        m_out = '0; m_pend = '0; m_valid = 1'b0; m_busy = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_out = '0; m_valid = 1'b0; m_busy = 0;
            end else begin
                cyc++;
                rdy = (m_busy == 0) && (!m_valid || out_ready);
                acc = in_valid && rdy;
                if (m_valid && out_ready) m_valid = 1'b0;
                if (m_busy > 0) begin
                    m_busy--;
                    if (m_busy == 0) begin m_valid = 1'b1; m_out = m_pend; end
                end
                if (acc) begin
                    e = ref_alu(op, src_a, src_b);
                    if (op >= 4'd10 && op <= 4'd13) begin m_busy = W + 1; m_pend = e; end
                    else begin m_valid = 1'b1; m_out = e; end
                end
            end
        end
    end

    initial begin
        bit exp_rdy;
        forever begin
            @(negedge clk);
            exp_rdy = (m_busy == 0) && (!m_valid || out_ready);
            chk("in_ready", 64'(in_ready), 64'(exp_rdy));
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            chk("result_flags", 64'({result, zero, negative, carry, overflow, illegal}), 64'(m_out));
        end
    end

    task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        bit acc;
        int budget;
        budget = 0;
        in_valid = 1'b1; op = o; src_a = a; src_b = b;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            if (acc) break;
            budget++;
            if (budget > 200) begin
                vectors++; miscompares++;
                $display("FAIL issue_timeout: in_ready got 0 required 1 within 200 cycles");
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        if (rnd) begin op = 4'($urandom); src_a = $urandom; src_b = $urandom; end
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic wait_valid(output int at);
        int budget;
        budget = 0;
        at = -1;
        in_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid) begin at = cyc; break; end
            budget++;
            if (budget > 100) begin
                vectors++; miscompares++;
                $display("FAIL wait_valid_timeout: out_valid got 0 required 1 within 100 cycles");
                break;
            end
        end
    endtask

    function automatic logic [W-1:0] pick_opnd();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'd1;
            2: return '1;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        out_t r;
        int   t0, t1;
        logic [W-1:0] xa, xb;

        // Model pins (hand-computed)
        r = ref_alu(4'd0, 32'h7FFF_FFFF, 32'd1);
        chk("pin_add_ovf", 64'(r), 64'({32'h8000_0000, 5'b01010}));
        r = ref_alu(4'd1, 32'd5, 32'd5);
        chk("pin_sub_zero", 64'(r), 64'({32'h0, 5'b10100}));
        r = ref_alu(4'd9, 32'h8000_0000, 32'd4);
        chk("pin_sra", 64'(r.res), 64'h F800_0000);
        r = ref_alu(4'd4, 32'hFFFF_FFFF, 32'd1);
        chk("pin_slt", 64'(r.res), 64'd1);
        r = ref_alu(4'd5, 32'hFFFF_FFFF, 32'd1);
        chk("pin_sltu", 64'(r.res), 64'd0);
        r = ref_alu(4'd11, 32'h1_0000, 32'h1_0000);
        chk("pin_mulhu", 64'(r.res), 64'd1);
        r = ref_alu(4'd12, 32'd100, 32'd7);
        chk("pin_divu", 64'(r.res), 64'd14);
        r = ref_alu(4'd13, 32'd100, 32'd7);
        chk("pin_remu", 64'(r.res), 64'd2);
        r = ref_alu(4'd12, 32'hDEAD_BEEF, 32'd0);
        chk("pin_divu_z", 64'(r.res), 64'h FFFF_FFFF);
        r = ref_alu(4'd15, 32'd3, 32'd4);
        chk("pin_illegal", 64'(r), 64'({32'h0, 5'b10001}));

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;

        // Signed overflow and zero/not-borrow
        issue(4'd0, 32'h7FFF_FFFF, 32'd1);
        chk("add_ovf_res", 64'(result), 64'h8000_0000);
        chk("add_ovf_flags", 64'({negative, carry, overflow}), 64'b101);
        issue(4'd1, 32'd5, 32'd5);
        chk("sub_zero_flags", 64'({zero, carry}), 64'b11);
        idle(2);

        // Back-to-back single-cycle ops
        xa = $urandom; xb = $urandom;
        issue(4'd6, xa, xb);
        issue(4'd7, 32'd1, 32'd31);
        chk("sll_res", 64'(result), 64'h8000_0000);
        issue(4'd9, 32'h8000_0000, 32'd4);
        issue(4'd4, 32'hFFFF_FFFF, 32'd1);
        issue(4'd5, 32'hFFFF_FFFF, 32'd1);
        idle(2);

        // Iterative latency
        issue(4'd10, 32'h1_0000, 32'h1_0000);
        t0 = cyc;
        wait_valid(t1);
        chk("mul_latency", 64'(t1 - t0), 64'(W + 1));
        chk("mul_res", 64'(result), 64'd0);
        issue(4'd11, 32'h1_0000, 32'h1_0000);
        t0 = cyc;
        wait_valid(t1);
        chk("mulhu_latency", 64'(t1 - t0), 64'(W + 1));
        chk("mulhu_res", 64'(result), 64'd1);

        issue(4'd12, 32'd100, 32'd7);  wait_valid(t1); chk("divu_res", 64'(result), 64'd14);
        issue(4'd13, 32'd100, 32'd7);  wait_valid(t1); chk("remu_res", 64'(result), 64'd2);
        issue(4'd12, 32'hDEAD_BEEF, 32'd0); wait_valid(t1); chk("divu_z_res", 64'(result), 64'hFFFF_FFFF);
        issue(4'd13, 32'h1234, 32'd0); wait_valid(t1); chk("remu_z_res", 64'(result), 64'h1234);
        idle(2);

        // Backpressure, then retire and accept in the same cycle
        out_ready = 1'b0;
        issue(4'd0, 32'd10, 32'd20);
        idle(5);
        chk("bp_hold_res", 64'(result), 64'd30);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        issue(4'd0, 32'd100, 32'd23);
        chk("bp_next_res", 64'(result), 64'd123);
        chk("bp_next_valid", 64'(out_valid), 64'd1);
        idle(2);

        // Reset in the middle of a divide
        issue(4'd12, 32'd1000, 32'd3);
        idle(10);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_result", 64'(result), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        issue(4'd0, 32'd2, 32'd3);
        chk("post_rst_add", 64'(result), 64'd5);
        issue(4'd15, 32'd7, 32'd9);
        chk("illegal_flag", 64'({illegal, result}), 64'({1'b1, 32'h0}));
        idle(2);

        // Randomized traffic with random backpressure and gaps
        rnd = 1'b1;
        repeat (400) begin
            issue(4'($urandom_range(0, 15)), pick_opnd(), pick_opnd());
            idle($urandom_range(0, 2));
        end
        rnd = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
